cpu_qsys_cpu_ocimem_monitor: RTL and testbench
==============================================

# cpu_qsys_cpu_ocimem_monitor

Debug-side on-chip memory monitor for the Nios II core. It sits directly downstream of the JTAG debug module wrapper's system-clock stage. It consumes `jdo` and the `take_action_ocimem_a/b` and `take_no_action_ocimem_a` pulses, sequences reads and writes into a private debug RAM, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper. It also exposes the same RAM to the CPU as an Avalon-MM slave, with JTAG accesses taking priority.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; RAM depth is 2^ADDR_W 32-bit words. Legal range is 2..24.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk`.
- `jdo`  in  38  JTAG data-out word, valid in the cycle of any action pulse.
- `take_action_ocimem_a`  in  1  one-cycle pulse: load address; optionally read.
- `take_action_ocimem_b`  in  1  one-cycle pulse: write data, then post-increment.
- `take_no_action_ocimem_a`  in  1  one-cycle pulse: pre-increment, then read.
- `MonDReg`  out  32  monitor data register.
- `monitor_ready`  out  1  last accepted JTAG operation has completed.
- `monitor_error`  out  1  a JTAG pulse was dropped.
- `address`  in  ADDR_W  CPU word address.
- `read`  in  1  CPU read request.
- `write`  in  1  CPU write request.
- `writedata`  in  32  CPU write data.
- `byteenable`  in  4  CPU byte lanes.
- `debugaccess`  in  1  CPU access is a debug-mode access.
- `waitrequest`  out  1  CPU request stalled this cycle.
- `readdata`  out  32  CPU read data, fixed latency of 1.

## Operation
jdo fields:
- Address: `jdo[ADDR_W+9:10]`.
- Read flag: `jdo[34]`.
- Write data: `jdo[34:3]`.

JTAG commands:
- `take_action_ocimem_a`:
  - Sets `MonAReg` from the address field.
  - Clears `monitor_error`.
  - If `jdo[34]` = 1, starts a read at the new `MonAReg`.
  - If `jdo[34]` = 0, completes immediately.
- `take_action_ocimem_b`:
  - Sets `MonDReg` to `jdo[34:3]`.
  - Writes that data, all lanes enabled, at `MonAReg`.
  - Then sets `MonAReg` to `MonAReg`+1.
- `take_no_action_ocimem_a`:
  - Sets `MonAReg` to `MonAReg`+1.
  - Then reads at the new address into `MonDReg`.
- `MonAReg` arithmetic is modulo 2^ADDR_W: the maximum address wraps to 0.

JTAG FSM, states IDLE, RD_ISSUE, RD_CAP, WR:
- IDLE: an accepted read goes to RD_ISSUE; an accepted write goes to WR; a load-only command stays in IDLE.
- RD_ISSUE → RD_CAP → IDLE.
- WR → IDLE.
- Every accepted pulse clears `monitor_ready`. The final state of the operation sets it again.

Pulse arbitration:
- Pulses are accepted only in IDLE.
- If a pulse arrives outside IDLE, it is dropped and `monitor_error` is set to 1.
- If several pulses arrive in the same cycle, priority is `action_a` > `action_b` > `no_action_a`. The losers are dropped and set `monitor_error`.

CPU port:
- `waitrequest` = (FSM ≠ IDLE) | (any JTAG pulse this cycle).
- A CPU read or write completes in a cycle where `waitrequest` = 0.
- Writes honour `byteenable`.

## Timing
Reset values (with `reset_n` = 0):
- `MonAReg` = 0, `MonDReg` = 0, `readdata` = 0.
- `monitor_ready` = 0, `monitor_error` = 0, `waitrequest` = 0.
- FSM = IDLE.
- RAM contents are not reset.

Latencies, with the pulse in cycle T:
- Read: RAM address is driven in T+1. Data is captured into `MonDReg` at the end of T+2. `monitor_ready` = 1 is visible from T+3.
- Write: the RAM write happens in T+1. `monitor_ready` = 1 is visible from T+2.
- Load-only: `monitor_ready` = 1 is visible from T+1.

CPU reads:
- `readdata` is valid in the cycle after acceptance.
- `readdata` holds its value otherwise.

Reset asserted mid-operation: the FSM returns to IDLE immediately and the operation is abandoned. Whether a partially started RAM write lands is undefined.

## Configuration
- `CPU_OCIMEM_WRPROT_EN` defined:
  - A CPU write with `debugaccess` = 0 is accepted and completes normally (`waitrequest` rules are unchanged).
  - The RAM is not modified.
- Macro not defined: all CPU writes modify the RAM.
- JTAG writes are never protected.

## Structure
- Package `cpu_qsys_ocimem_pkg` holds:
  - the FSM state enum;
  - jdo field position constants (`JDO_RDFLAG_BIT` = 34, `JDO_WDATA_HI` = 34, `JDO_WDATA_LO` = 3, `JDO_ADDR_LO` = 10).
- Sub-module `cpu_qsys_cpu_ocimem_ram`:
  - single-port synchronous RAM, 32 bits wide, with 4-bit byte enables;
  - 1-cycle read latency;
  - the top level muxes the JTAG and CPU ports into it.

## Test plan
- Write then read back: `action_a` with address 0x10 and read flag 0, then `action_b` with data 0xDEADBEEF. Expect `monitor_ready` at T+2 and `MonAReg` = 0x11. Then `action_a` with address 0x10 and read flag 1: `MonDReg` = 0xDEADBEEF and `monitor_ready` = 1 at T+3.
- Pre-increment read and wrap: load address 0xFE, then issue two `no_action_a` pulses. Expect reads of addresses 0xFF and then 0x00.
- Collision: `action_b` and `no_action_a` in the same cycle. Expect only the write, `monitor_error` = 1, and the error cleared by the next `action_a`.
- CPU priority: a CPU read is held with `read` = 1 during a JTAG read. Expect `waitrequest` = 1 for cycles T..T+2, acceptance at T+3, and `readdata` valid at T+4.
- Write protection, with the macro defined: a CPU write of 0x12345678 to address 0x05 with `debugaccess` = 0 must leave the RAM unchanged. The same write with `debugaccess` = 1 updates it. Byte enable 4'b0010 changes only bits [15:8].
- Reset mid-operation: assert `reset_n` in RD_ISSUE. All outputs must return to their reset values, and a read issued after reset works.

Source files
------------

// File: rtl/cpu_qsys_ocimem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_qsys_ocimem_pkg
// Shared definitions for the OCI debug memory monitor:
//   - ocimem_state_t : JTAG sequencing FSM states
//   - JDO_*          : field positions inside the 38-bit JTAG data-out word
//   - DATA_W / BE_W  : RAM word width and byte-lane count
// ---------------------------------------------------------------------------
package cpu_qsys_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_CAP   = 2'd2,
    WR       = 2'd3
  } ocimem_state_t;

  localparam int JDO_W          = 38;
  localparam int JDO_RDFLAG_BIT = 34;
  localparam int JDO_WDATA_HI   = 34;
  localparam int JDO_WDATA_LO   = 3;
  localparam int JDO_ADDR_LO    = 10;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

endpackage

// File: rtl/cpu_qsys_cpu_ocimem_ram.sv
// ---------------------------------------------------------------------------
// cpu_qsys_cpu_ocimem_ram
// Single-port synchronous RAM, 32-bit words, per-byte write enables,
// one-cycle registered read. Read data only changes in cycles where en=1,
// so the last read word stays on rdata until the next access.
// Each byte lane is its own array so byte enables map onto plain
// per-lane write enables.
// Ports:
//   clk    in   clock
//   en     in   access enable (read always happens when enabled)
//   we     in   byte-lane write enables (qualified by en)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data (old contents on a simultaneous write)
// ---------------------------------------------------------------------------
module cpu_qsys_cpu_ocimem_ram
  import cpu_qsys_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (en) begin
          if (we[gi]) begin
            lane_mem[addr] <= wdata[gi*8 +: 8];
          end
          lane_q_reg <= lane_mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

endmodule

// File: rtl/cpu_qsys_cpu_ocimem_monitor.sv
// ---------------------------------------------------------------------------
// cpu_qsys_cpu_ocimem_monitor
// Debug-side on-chip memory monitor. JTAG action pulses load/increment the
// monitor address, read the debug RAM into MonDReg or write jdo data into
// it. The same RAM is exposed to the CPU as an Avalon-MM slave; JTAG
// activity stalls the CPU through waitrequest.
//
// Optional feature: define CPU_OCIMEM_WRPROT_EN to make CPU writes with
// debugaccess=0 complete without modifying the RAM.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   jdo                           JTAG data word (addr, read flag, data)
//   take_action_ocimem_a          load address, optionally read
//   take_action_ocimem_b          write data, post-increment
//   take_no_action_ocimem_a       pre-increment, read
//   MonDReg                       monitor data register
//   monitor_ready                 last accepted JTAG operation complete
//   monitor_error                 a JTAG pulse was dropped
//   address/read/write/writedata/byteenable/debugaccess   CPU request
//   waitrequest                   CPU request stalled
//   readdata                      CPU read data, latency 1, held otherwise
// ---------------------------------------------------------------------------
module cpu_qsys_cpu_ocimem_monitor
  import cpu_qsys_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  input  logic              debugaccess,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata
);

  ocimem_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] mon_a_reg, mon_a_next;
  logic [DATA_W-1:0] mon_d_reg, mon_d_next;
  logic              ready_reg, ready_next;
  logic              error_reg, error_next;

  logic              cpu_rd_pend_reg;
  logic [DATA_W-1:0] rd_hold_reg;

  logic              ram_en;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              any_pulse;
  logic              pulse_drop;
  logic              cpu_wr_allow;
  logic              cpu_rd_accept;

  logic [ADDR_W-1:0] jdo_addr;
  logic [DATA_W-1:0] jdo_wdata;
  logic              jdo_rd;

  assign jdo_addr  = jdo[JDO_ADDR_LO +: ADDR_W];
  assign jdo_wdata = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
  assign jdo_rd    = jdo[JDO_RDFLAG_BIT];

  // jdo bits outside every field are intentionally ignored.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_WDATA_HI+1], jdo[JDO_WDATA_LO-1:0]};

`ifdef CPU_OCIMEM_WRPROT_EN
  assign cpu_wr_allow = debugaccess;
`else
  logic unused_debugaccess;
  assign unused_debugaccess = debugaccess;
  assign cpu_wr_allow       = 1'b1;
`endif

  assign any_pulse = take_action_ocimem_a | take_action_ocimem_b |
                     take_no_action_ocimem_a;

  // A pulse is lost when the FSM is busy or when it loses same-cycle
  // arbitration against a higher-priority pulse.
  assign pulse_drop = any_pulse &
                      ((state_reg != IDLE) |
                       (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a));

  assign waitrequest = (state_reg != IDLE) | any_pulse;

  // -------------------------------------------------------------------------
  // FSM state and register update.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      mon_a_reg       <= '0;
      mon_d_reg       <= '0;
      ready_reg       <= 1'b0;
      error_reg       <= 1'b0;
      cpu_rd_pend_reg <= 1'b0;
      rd_hold_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      mon_a_reg       <= mon_a_next;
      mon_d_reg       <= mon_d_next;
      ready_reg       <= ready_next;
      error_reg       <= error_next;
      cpu_rd_pend_reg <= cpu_rd_accept;
      rd_hold_reg     <= readdata;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, register next values and RAM port mux.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    mon_a_next    = mon_a_reg;
    mon_d_next    = mon_d_reg;
    ready_next    = ready_reg;
    error_next    = error_reg;
    ram_en        = 1'b0;
    ram_we        = '0;
    ram_addr      = address;
    ram_wdata     = writedata;
    cpu_rd_accept = 1'b0;

    case (state_reg)
      IDLE: begin
        if (take_action_ocimem_a) begin
          mon_a_next = jdo_addr;
          error_next = 1'b0;
          if (jdo_rd) begin
            state_next = RD_ISSUE;
            ready_next = 1'b0;
          end else begin
            ready_next = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          // Data is latched now and written from MonDReg next cycle.
          mon_d_next = jdo_wdata;
          state_next = WR;
          ready_next = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          mon_a_next = mon_a_reg + ADDR_W'(1);
          state_next = RD_ISSUE;
          ready_next = 1'b0;
        end else if (read | write) begin
          ram_en        = 1'b1;
          ram_we        = write ? (byteenable & {BE_W{cpu_wr_allow}}) : '0;
          cpu_rd_accept = read;
        end
      end
      RD_ISSUE: begin
        ram_en     = 1'b1;
        ram_addr   = mon_a_reg;
        state_next = RD_CAP;
      end
      RD_CAP: begin
        mon_d_next = ram_rdata;
        ready_next = 1'b1;
        state_next = IDLE;
      end
      WR: begin
        ram_en     = 1'b1;
        ram_we     = {BE_W{1'b1}};
        ram_addr   = mon_a_reg;
        ram_wdata  = mon_d_reg;
        mon_a_next = mon_a_reg + ADDR_W'(1);
        ready_next = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Setting the error wins over the clear from an accepted action_a,
    // so a collision that action_a wins still reports the dropped loser.
    if (pulse_drop) begin
      error_next = 1'b1;
    end
  end

  // CPU read data comes straight off the RAM output register in the cycle
  // after acceptance and is held from a local copy afterwards, since JTAG
  // reads later reuse the RAM output.
  assign readdata = cpu_rd_pend_reg ? ram_rdata : rd_hold_reg;

  assign MonDReg       = mon_d_reg;
  assign monitor_ready = ready_reg;
  assign monitor_error = error_reg;

  cpu_qsys_cpu_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_cpu_qsys_cpu_ocimem_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_qsys_cpu_ocimem_monitor
// Scoreboard bench: stimulus tasks update a word-array memory model and push
// expected JTAG / CPU responses into queues; two monitor processes pop and
// compare when the DUT completes an operation.
// ---------------------------------------------------------------------------
module tb_cpu_qsys_cpu_ocimem_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;
  logic        waitrequest;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  cpu_qsys_cpu_ocimem_monitor #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .waitrequest             (waitrequest),
    .readdata                (readdata)
  );

  typedef struct {
    int          lat;
    logic [31:0] d;
    logic        err;
    bit          abort;
  } jexp_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] d;
    int          waits;
  } cexp_t;

  jexp_t jq[$];
  cexp_t cq[$];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] model_mem [256];
  logic [7:0]  model_a   = '0;
  logic [31:0] model_d   = '0;
  logic        model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] rand_jdo();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit pa, input bit pb, input bit pn,
                       input logic [37:0] j, input int lat);
    jdo = j;
    take_action_ocimem_a    = pa;
    take_action_ocimem_b    = pb;
    take_no_action_ocimem_a = pn;
    @(posedge clk); #1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    repeat (lat) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] addr, input bit rd);
    logic [37:0] j;
    j = rand_jdo();
    j[17:10] = addr;
    j[34] = rd;
    model_a   = addr;
    model_err = 1'b0;
    if (rd) model_d = model_mem[addr];
    jq.push_back('{rd ? 3 : 1, model_d, 1'b0, 1'b0});
    issue(1'b1, 1'b0, 1'b0, j, rd ? 3 : 1);
  endtask

  task automatic do_write(input logic [31:0] data);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = data;
    model_mem[model_a] = data;
    model_d = data;
    model_a = model_a + 8'd1;
    jq.push_back('{2, model_d, model_err, 1'b0});
    issue(1'b0, 1'b1, 1'b0, j, 2);
  endtask

  task automatic do_preinc();
    model_a = model_a + 8'd1;
    model_d = model_mem[model_a];
    jq.push_back('{3, model_d, model_err, 1'b0});
    issue(1'b0, 1'b0, 1'b1, rand_jdo(), 3);
  endtask

  task automatic cpu_wait_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitrequest && n < 20);
    @(posedge clk); #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input bit dbg);
    bit allow = 1'b1;
`ifdef CPU_OCIMEM_WRPROT_EN
    allow = dbg;
`endif
    if (allow) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[addr][b*8 +: 8] = data[b*8 +: 8];
    end
    cq.push_back('{1'b0, 32'h0, 0});
    address = addr; writedata = data; byteenable = be; debugaccess = dbg;
    write = 1'b1;
    cpu_wait_accept();
  endtask

  task automatic cpu_read(input logic [7:0] addr);
    cq.push_back('{1'b1, model_mem[addr], 0});
    address = addr;
    read = 1'b1;
    cpu_wait_accept();
  endtask

  // ---------------- JTAG monitor ----------------
  initial begin : jtag_mon
    jexp_t it;
    int    n;
    bit    aborted, seen;
    forever begin
      @(negedge clk);
      if (reset_n && (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a)) begin
        chk("jtag_expect_queued", 32'(jq.size() > 0), 32'd1);
        if (jq.size() > 0) begin
          it = jq.pop_front();
          n = 0; aborted = 1'b0; seen = 1'b0;
          while (!seen && !aborted && n <= 20) begin
            @(negedge clk);
            n++;
            if (!reset_n) aborted = 1'b1;
            else if (monitor_ready) seen = 1'b1;
          end
          if (it.abort) begin
            chk("jtag_abort_by_reset", 32'(aborted), 32'd1);
          end else begin
            chk("jtag_ready_latency", 32'(n), 32'(it.lat));
            chk("MonDReg", MonDReg, it.d);
            chk("monitor_error", 32'(monitor_error), 32'(it.err));
          end
        end
      end
    end
  end

  // ---------------- CPU monitor ----------------
  initial begin : cpu_mon
    cexp_t       it;
    int          wc = 0;
    bit          pend = 1'b0;
    logic [31:0] pd = '0;
    logic [31:0] last = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        wc = 0; pend = 1'b0; last = '0;
        chk("readdata_reset", readdata, last);
      end else begin
        if (pend) begin
          last = pd;
          pend = 1'b0;
        end
        chk("readdata", readdata, last);
        if (read || write) begin
          if (waitrequest) begin
            wc++;
          end else begin
            chk("cpu_expect_queued", 32'(cq.size() > 0), 32'd1);
            if (cq.size() > 0) begin
              it = cq.pop_front();
              chk("cpu_wait_cycles", 32'(wc), 32'(it.waits));
              if (it.is_rd) begin
                pend = 1'b1;
                pd = it.d;
              end
            end
            wc = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0]  xa, ya;
    logic [37:0] j;
    int          n;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_monitor_ready", 32'(monitor_ready), 32'd0);
    chk("rst_monitor_error", 32'(monitor_error), 32'd0);
    chk("rst_waitrequest", 32'(waitrequest), 32'd0);
    chk("rst_readdata", readdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill the whole RAM through JTAG; the last write wraps MonAReg to 0.
    do_load(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) do_write($urandom());
    do_preinc();

    // Write then read back.
    do_load(8'h10, 1'b0);
    do_write(32'hDEADBEEF);
    do_preinc();
    do_load(8'h10, 1'b1);

    // Pre-increment wrap.
    do_load(8'hFE, 1'b0);
    do_preinc();
    do_preinc();

    // Collision: action_b beats no_action_a; error sticks until action_a.
    j = rand_jdo();
    j[34:3] = 32'hA5A5_0F0F;
    model_mem[model_a] = 32'hA5A5_0F0F;
    model_d   = 32'hA5A5_0F0F;
    model_a   = model_a + 8'd1;
    model_err = 1'b1;
    jq.push_back('{2, model_d, 1'b1, 1'b0});
    issue(1'b0, 1'b1, 1'b1, j, 2);
    do_preinc();
    do_load(8'($urandom_range(0, 255)), 1'b1);

    // Pulse during a busy read is dropped and flags an error.
    xa = 8'($urandom_range(0, 255));
    j = rand_jdo(); j[17:10] = xa; j[34] = 1'b1;
    model_a = xa; model_d = model_mem[xa]; model_err = 1'b1;
    jq.push_back('{3, model_d, 1'b1, 1'b0});
    jdo = j; take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    jdo = rand_jdo(); take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_load(model_a, 1'b0);

    // CPU read held across a JTAG read.
    xa = 8'($urandom_range(0, 255));
    ya = 8'($urandom_range(0, 255));
    j = rand_jdo(); j[17:10] = xa; j[34] = 1'b1;
    model_a = xa; model_d = model_mem[xa]; model_err = 1'b0;
    jq.push_back('{3, model_d, 1'b0, 1'b0});
    cq.push_back('{1'b1, model_mem[ya], 3});
    jdo = j; take_action_ocimem_a = 1'b1;
    address = ya; read = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    cpu_wait_accept();
    @(posedge clk); #1;

    // CPU write protection and byte lanes.
    cpu_write(8'h05, 32'h12345678, 4'hF, 1'b0);
    cpu_read(8'h05);
    cpu_write(8'h05, 32'h12345678, 4'hF, 1'b1);
    cpu_read(8'h05);
    cpu_write(8'h05, 32'hCAFEF00D, 4'b0010, 1'b1);
    cpu_read(8'h05);
    do_load(8'h05, 1'b1);

    // Reset while the FSM is in RD_ISSUE.
    xa = 8'($urandom_range(0, 255));
    j = rand_jdo(); j[17:10] = xa; j[34] = 1'b1;
    jq.push_back('{0, 32'h0, 1'b0, 1'b1});
    jdo = j; take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_MonDReg", MonDReg, 32'h0);
    chk("midrst_monitor_ready", 32'(monitor_ready), 32'd0);
    chk("midrst_monitor_error", 32'(monitor_error), 32'd0);
    chk("midrst_waitrequest", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_a = '0; model_d = '0; model_err = 1'b0;
    @(posedge clk); #1;
    do_preinc();
    do_load(xa, 1'b1);

    // Randomized mix.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: do_load(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        1: do_write($urandom());
        2: do_preinc();
        3: cpu_read(8'($urandom_range(0, 255)));
        default: cpu_write(8'($urandom_range(0, 255)), $urandom(),
                           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      endcase
    end

    n = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("jtag_queue_drained", 32'(jq.size()), 32'(n));
    chk("cpu_queue_drained", 32'(cq.size()), 32'(n));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
